sort4_ctrl: RTL

- Sequential sorting engine that time-shares a single instance of the team's 4-bit magnitude comparator (comp) to bubble-sort N W-bit values, one compare-and-swap per clock.
- Sits between a loader (presents packed vector plus start pulse) and a consumer (samples sorted vector on done).
- Reports the number of swaps performed, for debug and test.

---
 rtl/sort_pkg.sv | 23 ++
 rtl/comp.sv | 14 +
 rtl/sort4_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sequential sorter: FSM encodings and
// elaboration-time helpers for sizing the compare schedule.
package sort_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CMP  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Compare-and-swap steps for a full bubble sort of n elements.
  function automatic int ncmp(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/comp.sv
// 4-bit unsigned magnitude comparator, shared by the sorting engine.
module comp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       greater,
  output logic       less,
  output logic       equal
);

  assign greater = (a > b);
  assign less    = (a < b);
  assign equal   = (a == b);

endmodule

// File: rtl/sort4_ctrl.sv
// Bubble-sort engine: one compare-and-swap per clock on a single shared
// comparator, fixed data-independent schedule of NCMP steps.
//
// state | meaning
// IDLE  | waiting for start, registers hold last result
// CMP   | one compare-and-swap per clock on pair (j, j+1)
// DONE  | one-cycle done pulse, result valid
module sort4_ctrl
  import sort_pkg::*;
#(
  parameter  int W    = 4,
  parameter  int N    = 4,
  localparam int NCMP = ncmp(N),
  localparam int CW   = clog2(NCMP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           ascending,
  input  logic [N*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] dout,
  output logic [CW-1:0]  swap_count
);

  localparam int IW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 2);

  state_t        state;
  logic [W-1:0]  work [N];
  logic          mode;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] jn;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          gt;
  logic          lt;
  logic          eq;
  logic          do_swap;
  logic          last_pair;
  logic          final_step;

  assign jn   = j + IW'(1);
  assign op_a = work[j];
  assign op_b = work[jn];

  comp u_comp (
    .a      (op_a),
    .b      (op_b),
    .greater(gt),
    .less   (lt),
    .equal  (eq)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign do_swap    = !eq && (mode ? gt : lt);
  assign last_pair  = (j == LAST - i);
  assign final_step = (i == LAST) && (j == '0);

  assign busy = (state == CMP) || (state == DONE);
  assign done = (state == DONE);

  for (genvar k = 0; k < N; k++) begin : g_dout
    assign dout[k*W +: W] = work[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      i          <= '0;
      j          <= '0;
      swap_count <= '0;
      for (int k = 0; k < N; k++) work[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) work[k] <= din[k*W +: W];
            mode       <= ascending;
            i          <= '0;
            j          <= '0;
            swap_count <= '0;
            state      <= CMP;
          end
        end
        CMP: begin
          if (do_swap) begin
            work[j]    <= op_b;
            work[jn]   <= op_a;
            swap_count <= swap_count + CW'(1);
          end
          if (last_pair) begin
            j <= '0;
            i <= i + IW'(1);
          end else begin
            j <= jn;
          end
          if (final_step) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
